// File: rtl/q_rx_decim.sv
// Q-branch receive decimator: two cascaded 7-tap half-band decimate-by-2 stages.
// Every rate is a clock enable on clk; ovf is sticky until reset.
module q_rx_decim_hb #(
  parameter int DATA_W = 18,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] data,
  output logic signed [DATA_W-1:0] out,
  output logic                     out_valid,
  output logic                     sat
);
  localparam int MAX_I = (1 << (DATA_W - 1)) - 1;
  localparam int MIN_I = -(1 << (DATA_W - 1));
  localparam logic signed [ACC_W-1:0]  MAX_A = ACC_W'(MAX_I);
  localparam logic signed [ACC_W-1:0]  MIN_A = ACC_W'(MIN_I);
  localparam logic signed [DATA_W-1:0] MAX_D = DATA_W'(MAX_I);
  localparam logic signed [DATA_W-1:0] MIN_D = DATA_W'(MIN_I);
  localparam logic signed [ACC_W-1:0]  HALF  = ACC_W'(16);

  logic signed [DATA_W-1:0] d [7];
  logic                     phase;
  logic signed [ACC_W-1:0]  t0, t2, t3, t4, t6;
  logic signed [ACC_W-1:0]  pair, acc, rnd;
  logic signed [DATA_W-1:0] res;
  logic                     sat_hit;

  // Taps are taken from the post-shift line so the new sample lands in this edge's sum.
  always_comb begin
    t0   = {{(ACC_W-DATA_W){data[DATA_W-1]}}, data};
    t2   = {{(ACC_W-DATA_W){d[1][DATA_W-1]}}, d[1]};
    t3   = {{(ACC_W-DATA_W){d[2][DATA_W-1]}}, d[2]};
    t4   = {{(ACC_W-DATA_W){d[3][DATA_W-1]}}, d[3]};
    t6   = {{(ACC_W-DATA_W){d[5][DATA_W-1]}}, d[5]};
    pair = t2 + t4;
    acc  = (t3 <<< 4) + (pair <<< 3) + pair - t0 - t6;
    rnd  = (acc + HALF) >>> 5;
    sat_hit = 1'b0;
    res     = rnd[DATA_W-1:0];
    if (rnd > MAX_A) begin
      res     = MAX_D;
      sat_hit = 1'b1;
    end else if (rnd < MIN_A) begin
      res     = MIN_D;
      sat_hit = 1'b1;
    end
  end

  assign sat = in_valid & phase & sat_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 7; k++) d[k] <= '0;
      phase     <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        d[0] <= data;
        for (int k = 1; k < 7; k++) d[k] <= d[k-1];
        phase <= ~phase;
        if (phase) begin
          out       <= res;
          out_valid <= 1'b1;
        end
      end
    end
  end
endmodule

module q_rx_decim #(
  parameter int DATA_W = 18,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     x_in_valid,
  input  logic signed [DATA_W-1:0] x_in,
  output logic signed [DATA_W-1:0] y_mid,
  output logic                     y_mid_valid,
  output logic signed [DATA_W-1:0] y,
  output logic                     y_valid,
  output logic                     ovf
);
  logic sat1, sat2;

  q_rx_decim_hb #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_stage1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (x_in_valid),
    .data      (x_in),
    .out       (y_mid),
    .out_valid (y_mid_valid),
    .sat       (sat1)
  );

  q_rx_decim_hb #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_stage2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (y_mid_valid),
    .data      (y_mid),
    .out       (y),
    .out_valid (y_valid),
    .sat       (sat2)
  );

  always_ff @(posedge clk) begin
    if (reset) ovf <= 1'b0;
    else if (sat1 | sat2) ovf <= 1'b1;
  end
endmodule

// File: tb/tb_q_rx_decim.sv
// Bench for q_rx_decim: randomized and directed streams against a convolution model.
module tb_q_rx_decim;
  localparam int DATA_W = 18;
  localparam int ACC_W  = 24;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     x_in_valid = 1'b0;
  logic signed [DATA_W-1:0] x_in = '0;
  logic signed [DATA_W-1:0] y_mid, y;
  logic                     y_mid_valid, y_valid, ovf;

  int checks = 0;
  int errors = 0;

  // Reference model: each stage output is the coefficient dot product over its input history.
  int coef [7] = '{-1, 0, 9, 16, 9, 0, -1};
  int h1[$];
  int h2[$];
  int exp_mid = 0, exp_y = 0;
  bit exp_mid_v = 0, exp_y_v = 0, exp_ovf = 0;
  int cyc = 0;

  q_rx_decim #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .x_in_valid  (x_in_valid),
    .x_in        (x_in),
    .y_mid       (y_mid),
    .y_mid_valid (y_mid_valid),
    .y           (y),
    .y_valid     (y_valid),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  function automatic int hb(input int q[$], output bit sat);
    int s = 0;
    int r;
    sat = 0;
    for (int k = 0; k < 7; k++) begin
      int idx;
      idx = q.size() - 1 - k;
      if (idx >= 0) s += coef[k] * q[idx];
    end
    r = (s + 16) >>> 5;
    if (r > 131071) begin r = 131071; sat = 1; end
    else if (r < -131072) begin r = -131072; sat = 1; end
    return r;
  endfunction

  // Drive one clock of stimulus, then advance the model to the post-edge state.
  task automatic cycle(input bit rst, input bit v, input int val);
    bit mv, s;
    int mval;
    reset = rst;
    x_in_valid = v;
    x_in = DATA_W'(val);
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      h1.delete(); h2.delete();
      exp_mid = 0; exp_y = 0; exp_mid_v = 0; exp_y_v = 0; exp_ovf = 0;
    end else begin
      mv = exp_mid_v;
      mval = exp_mid;
      exp_mid_v = 0;
      exp_y_v = 0;
      if (v) begin
        h1.push_back(val);
        if (h1.size() % 2 == 0) begin
          exp_mid = hb(h1, s);
          exp_mid_v = 1;
          if (s) exp_ovf = 1;
        end
      end
      if (mv) begin
        h2.push_back(mval);
        if (h2.size() % 2 == 0) begin
          exp_y = hb(h2, s);
          exp_y_v = 1;
          if (s) exp_ovf = 1;
        end
      end
    end
    reset = 0;
    x_in_valid = 0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    checks++; if (y_mid !== 0) begin errors++; $display("FAIL reset_y_mid got %0d exp 0", y_mid); end
    checks++; if (y !== 0) begin errors++; $display("FAIL reset_y got %0d exp 0", y); end
    checks++; if (y_mid_valid !== 1'b0) begin errors++; $display("FAIL reset_y_mid_valid got %b exp 0", y_mid_valid); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid got %b exp 0", y_valid); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
  endtask

  task automatic test_dc();
    int nin = 0, nv = 0, last_strobe = -10;
    cycle(1, 0, 0);
    for (int c = 0; c < 320; c++) begin
      cycle(0, (c % 4) == 0, 1000);
      if ((c % 4) == 0) begin nin++; last_strobe = c; end
      checks++;
      if (y_valid !== exp_y_v) begin errors++; $display("FAIL dc_y_valid c=%0d got %b exp %b", c, y_valid, exp_y_v); end
      if (y_valid === 1'b1) begin
        nv++;
        checks++;
        if (c != last_strobe + 1 || (nin % 4) != 0) begin
          errors++; $display("FAIL dc_y_valid_timing c=%0d got strobe_lag %0d inputs %0d exp lag 1 inputs mult 4", c, c - last_strobe, nin);
        end
        if (nin > 16) begin
          checks++; if (y !== 1000) begin errors++; $display("FAIL dc_y c=%0d got %0d exp 1000", c, y); end
        end
      end
      if (y_mid_valid === 1'b1 && nin > 16) begin
        checks++; if (y_mid !== 1000) begin errors++; $display("FAIL dc_y_mid c=%0d got %0d exp 1000", c, y_mid); end
      end
    end
    checks++; if (nv != 20) begin errors++; $display("FAIL dc_y_valid_count got %0d exp 20", nv); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL dc_ovf got %b exp 0", ovf); end
  endtask

  task automatic test_impulse();
    int qm[$];
    int qy[$];
    int em [12] = '{-100, 900, 900, -100, 0, 0, 0, 0, 0, 0, 0, 0};
    int ey [6]  = '{-28, 206, 675, -56, 3, 0};
    cycle(1, 0, 0);
    for (int c = 0; c < 28; c++) begin
      cycle(0, c < 24, (c == 1) ? 3200 : 0);
      if (y_mid_valid === 1'b1) qm.push_back(int'(y_mid));
      if (y_valid === 1'b1) qy.push_back(int'(y));
    end
    checks++; if (qm.size() != 12) begin errors++; $display("FAIL imp_mid_count got %0d exp 12", qm.size()); end
    checks++; if (qy.size() != 6) begin errors++; $display("FAIL imp_y_count got %0d exp 6", qy.size()); end
    for (int i = 0; i < 12 && i < qm.size(); i++) begin
      checks++; if (qm[i] != em[i]) begin errors++; $display("FAIL imp_mid[%0d] got %0d exp %0d", i, qm[i], em[i]); end
    end
    for (int i = 0; i < 6 && i < qy.size(); i++) begin
      checks++; if (qy[i] != ey[i]) begin errors++; $display("FAIL imp_y[%0d] got %0d exp %0d", i, qy[i], ey[i]); end
    end
  endtask

  task automatic test_saturation();
    int tbl [8] = '{0, -131072, 0, 131071, 131071, 131071, 0, -131072};
    int nm = 0;
    cycle(1, 0, 0);
    for (int c = 0; c < 40; c++) begin
      cycle(0, c < 24, (c < 8) ? tbl[c] : 0);
      if (y_mid_valid === 1'b1) begin
        nm++;
        if (nm == 4) begin
          checks++; if (y_mid !== 131071) begin errors++; $display("FAIL sat_mid4 got %0d exp 131071", y_mid); end
        end
      end
      if (c >= 8) begin
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky c=%0d got %b exp 1", c, ovf); end
      end
    end
    cycle(1, 0, 0);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_cleared got %b exp 0", ovf); end
  endtask

  task automatic test_reset_mid();
    int ns = 0;
    bit seen = 0;
    cycle(1, 0, 0);
    for (int c = 0; c < 9; c++) cycle(0, (c % 4) == 0, 1000);
    cycle(1, 0, 0);
    checks++;
    if (y_mid !== 0 || y !== 0 || y_mid_valid !== 0 || y_valid !== 0 || ovf !== 0) begin
      errors++; $display("FAIL rmid_cleared got y_mid=%0d y=%0d vm=%b vy=%b ovf=%b exp all 0", y_mid, y, y_mid_valid, y_valid, ovf);
    end
    for (int c = 0; c < 12; c++) begin
      cycle(0, (c % 4) == 0, 1000);
      if ((c % 4) == 0) ns++;
      if (y_mid_valid === 1'b1 && !seen) begin
        seen = 1;
        checks++; if (ns != 2) begin errors++; $display("FAIL rmid_first_strobe got %0d exp 2", ns); end
        checks++; if (y_mid !== -31) begin errors++; $display("FAIL rmid_first_value got %0d exp -31", y_mid); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rmid_no_output got none exp one"); end
  endtask

  task automatic test_strobe_in_reset();
    for (int c = 0; c < 10; c++) cycle(0, 1, int'($urandom_range(20000)) - 10000);
    for (int c = 0; c < 3; c++) begin
      cycle(1, 1, int'($urandom_range(20000)) - 10000);
      checks++;
      if (y_mid_valid !== 0 || y_valid !== 0) begin
        errors++; $display("FAIL sir_valid c=%0d got vm=%b vy=%b exp 0 0", c, y_mid_valid, y_valid);
      end
    end
    for (int c = 0; c < 40; c++) begin
      cycle(0, $urandom_range(1) == 1, int'($urandom_range(20000)) - 10000);
      checks++;
      if (y_mid_valid !== exp_mid_v || y_mid !== exp_mid || y_valid !== exp_y_v || y !== exp_y) begin
        errors++; $display("FAIL sir_after c=%0d got vm=%b m=%0d vy=%b y=%0d exp vm=%b m=%0d vy=%b y=%0d",
                           c, y_mid_valid, y_mid, y_valid, y, exp_mid_v, exp_mid, exp_y_v, exp_y);
      end
    end
  endtask

  task automatic test_random();
    int val;
    bit v;
    cycle(1, 0, 0);
    for (int c = 0; c < 800; c++) begin
      v = (c < 400) ? 1'b1 : ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) val = int'($urandom_range(262143)) - 131072;
      else val = int'($urandom_range(8000)) - 4000;
      cycle(0, v, val);
      checks++; if (y_mid_valid !== exp_mid_v) begin errors++; $display("FAIL rnd_mid_valid c=%0d got %b exp %b", c, y_mid_valid, exp_mid_v); end
      checks++; if (y_mid !== exp_mid) begin errors++; $display("FAIL rnd_mid c=%0d got %0d exp %0d", c, y_mid, exp_mid); end
      checks++; if (y_valid !== exp_y_v) begin errors++; $display("FAIL rnd_y_valid c=%0d got %b exp %b", c, y_valid, exp_y_v); end
      checks++; if (y !== exp_y) begin errors++; $display("FAIL rnd_y c=%0d got %0d exp %0d", c, y, exp_y); end
      checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL rnd_ovf c=%0d got %b exp %b", c, ovf, exp_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_impulse();
    test_saturation();
    test_reset_mid();
    test_strobe_in_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
